// File: rtl/regfile_wb_queue.sv
// Write-back queue for the register file: buffers write requests, drains them
// with a setup cycle before each regwrite strobe, and forwards pending data to two read lookups.
module regfile_wb_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   output logic                     regwrite,
   output logic [AW-1:0]            writer,
   output logic [DW-1:0]            writedata,
   input  logic [AW-1:0]            r1,
   input  logic [AW-1:0]            r2,
   output logic                     fwd1_hit,
   output logic [DW-1:0]            fwd1_data,
   output logic                     fwd2_hit,
   output logic [DW-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   head, tail;
   logic [PW-1:0]   load_ptr;
   logic            load;
   logic            push, pop;
   logic [AW-1:0]   mem_addr [DEPTH];
   logic [DW-1:0]   mem_data [DEPTH];

   // Register 0 requests complete the handshake but are never stored.
   assign in_ready = (count < CW'(DEPTH));
   assign empty    = (count == '0);
   assign push     = in_valid && in_ready && (in_addr != '0);
   assign pop      = (state_q == STROBE);

   // Drain sequencing; load selects the entry presented during the next SETUP.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_ptr = head;
      case (state_q)
         IDLE: begin
            if (count != '0) begin
               state_d = SETUP;
               load    = 1'b1;
            end
         end
         SETUP: begin
            state_d = STROBE;
         end
         STROBE: begin
            if (count > CW'(1)) begin
               state_d  = SETUP;
               load     = 1'b1;
               load_ptr = head + PW'(1);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         regwrite  <= 1'b0;
         writer    <= '0;
         writedata <= '0;
      end else begin
         state_q  <= state_d;
         regwrite <= (state_d == STROBE);
         if (load) begin
            writer    <= mem_addr[load_ptr];
            writedata <= mem_data[load_ptr];
         end
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: only entries between head and head+count are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[tail] <= in_addr;
         mem_data[tail] <= in_data;
      end
   end

   // Scan oldest to newest so the newest matching entry overrides older ones.
   always_comb begin
      logic [PW-1:0] idx;
      idx       = '0;
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count) begin
            if ((r1 != '0) && (mem_addr[idx] == r1)) begin
               fwd1_hit  = 1'b1;
               fwd1_data = mem_data[idx];
            end
            if ((r2 != '0) && (mem_addr[idx] == r2)) begin
               fwd2_hit  = 1'b1;
               fwd2_data = mem_data[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: per-cycle vector table plus streamed
// sequences checked against a pending-write queue model.
module tb_regfile_wb_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [31:0] in_data;
   logic        regwrite;
   logic [4:0]  writer;
   logic [31:0] writedata;
   logic [4:0]  r1, r2;
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;
   logic [2:0]  count;
   logic        empty;

   regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .regwrite(regwrite), .writer(writer), .writedata(writedata),
      .r1(r1), .r2(r2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .count(count), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic [4:0]  a;
      logic [31:0] d;
      logic [4:0]  q1;
      logic [4:0]  q2;
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [2:0]  cnt;
      logic        rdy;
      logic        h1;
      logic [31:0] f1;
      logic        h2;
      logic [31:0] f2;
   } vec_t;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   vec_t        tbl [19];
   ent_t        pend [$];
   int          n_vec = 0;
   int          n_err = 0;
   int          s_n;
   logic [4:0]  s_addr [16];
   logic [31:0] s_data [16];
   bit          saw_full;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   function automatic void model_fwd(input logic [4:0] r, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      foreach (pend[i]) begin
         if (r != 5'd0 && pend[i].a == r) begin
            h = 1'b1;
            d = pend[i].d;
         end
      end
   endfunction

   // Streams s_addr/s_data through the handshake; model is updated at each edge.
   task automatic run_stream();
      int         idx;
      int         cyc;
      int         nz;
      int         ncommit;
      logic       rdy, rw, prev_rw, eh1, eh2;
      logic [31:0] ed1, ed2;
      idx = 0; cyc = 0; nz = 0; ncommit = 0; prev_rw = 1'b0; saw_full = 1'b0;
      for (int i = 0; i < s_n; i++) if (s_addr[i] != 5'd0) nz++;
      while ((idx < s_n || pend.size() != 0) && cyc < 300) begin
         in_valid = (idx < s_n);
         in_addr  = (idx < s_n) ? s_addr[idx] : 5'd0;
         in_data  = (idx < s_n) ? s_data[idx] : 32'd0;
         r1       = 5'($urandom_range(0, 12));
         r2       = 5'($urandom_range(0, 12));
         @(negedge clk);
         n_vec++;
         rdy = in_ready;
         rw  = regwrite;
         model_fwd(r1, eh1, ed1);
         model_fwd(r2, eh2, ed2);
         chk("stream_fwd1_hit", 32'(fwd1_hit), 32'(eh1));
         chk("stream_fwd1_data", fwd1_data, ed1);
         chk("stream_fwd2_hit", 32'(fwd2_hit), 32'(eh2));
         chk("stream_fwd2_data", fwd2_data, ed2);
         chk("stream_count", 32'(count), 32'(pend.size()));
         chk("stream_in_ready", 32'(rdy), 32'(pend.size() < 4));
         if (rw) begin
            ncommit++;
            chk("stream_strobe_width", 32'(prev_rw), 32'd0);
            if (pend.size() == 0) chk("stream_spurious_strobe", 32'(rw), 32'd0);
            else begin
               chk("stream_writer", 32'(writer), 32'(pend[0].a));
               chk("stream_writedata", writedata, pend[0].d);
            end
         end
         if (!rdy) saw_full = 1'b1;
         prev_rw = rw;
         @(posedge clk);
         if (rw && pend.size() != 0) void'(pend.pop_front());
         if (in_valid && rdy) begin
            if (in_addr != 5'd0) pend.push_back({in_addr, in_data});
            idx++;
         end
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      chk("stream_budget", 32'(cyc < 300), 32'd1);
      chk("stream_commits", 32'(ncommit), 32'(nz));
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; r1 = '0; r2 = '0;

      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        3'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[5]  = '{1'b1, 5'd7, 32'hA,        5'd7, 5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 3'd1, 1'b1, 1'b1, 32'hA,        1'b1, 32'hA};
      tbl[6]  = '{1'b1, 5'd7, 32'hB,        5'd7, 5'd7, 1'b0, 5'd7, 32'hA,        3'd2, 1'b1, 1'b1, 32'hB,        1'b1, 32'hB};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 5'd7, 32'hA,        3'd2, 1'b1, 1'b1, 32'hB,        1'b1, 32'hB};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd7, 32'hB,        3'd1, 1'b1, 1'b1, 32'hB,        1'b1, 32'hB};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 5'd7, 32'hB,        3'd1, 1'b1, 1'b1, 32'hB,        1'b1, 32'hB};
      tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd7, 32'hB,        3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[11] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd7, 32'hB,        3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd7, 32'hB,        3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tbl[13] = '{1'b1, 5'd3, 32'h33,       5'd3, 5'd7, 1'b0, 5'd7, 32'hB,        3'd1, 1'b1, 1'b1, 32'h33,       1'b0, 32'h0};
      tbl[14] = '{1'b1, 5'd9, 32'h99,       5'd3, 5'd9, 1'b0, 5'd3, 32'h33,       3'd2, 1'b1, 1'b1, 32'h33,       1'b1, 32'h99};
      tbl[15] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 1'b1, 5'd3, 32'h33,       3'd2, 1'b1, 1'b1, 32'h33,       1'b1, 32'h99};
      tbl[16] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 1'b0, 5'd9, 32'h99,       3'd1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h99};
      tbl[17] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 1'b1, 5'd9, 32'h99,       3'd1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h99};
      tbl[18] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 1'b0, 5'd9, 32'h99,       3'd0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};

      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      chk("reset_regwrite", 32'(regwrite), 32'd0);
      chk("reset_writer", 32'(writer), 32'd0);
      chk("reset_writedata", writedata, 32'd0);
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Each record: inputs held across one edge, outputs sampled just after it.
      for (int k = 0; k < 19; k++) begin
         in_valid = tbl[k].vld; in_addr = tbl[k].a; in_data = tbl[k].d;
         r1 = tbl[k].q1; r2 = tbl[k].q2;
         @(posedge clk); #1;
         n_vec++;
         chk($sformatf("v%0d_regwrite", k), 32'(regwrite), 32'(tbl[k].rw));
         chk($sformatf("v%0d_writer", k), 32'(writer), 32'(tbl[k].wr));
         chk($sformatf("v%0d_writedata", k), writedata, tbl[k].wd);
         chk($sformatf("v%0d_count", k), 32'(count), 32'(tbl[k].cnt));
         chk($sformatf("v%0d_empty", k), 32'(empty), 32'(tbl[k].cnt == 3'd0));
         chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
         chk($sformatf("v%0d_fwd1_hit", k), 32'(fwd1_hit), 32'(tbl[k].h1));
         chk($sformatf("v%0d_fwd1_data", k), fwd1_data, tbl[k].f1);
         chk($sformatf("v%0d_fwd2_hit", k), 32'(fwd2_hit), 32'(tbl[k].h2));
         chk($sformatf("v%0d_fwd2_data", k), fwd2_data, tbl[k].f2);
      end
      in_valid = 1'b0; in_addr = '0; in_data = '0;

      // Fill: six back-to-back requests must hit a full queue and stall once.
      s_n = 6;
      for (int i = 0; i < 6; i++) begin
         s_addr[i] = 5'(i + 1);
         s_data[i] = 32'((i + 1) * 32'h11);
      end
      run_stream();
      n_vec++;
      chk("fill_saw_full", 32'(saw_full), 32'd1);

      // Wrap-around: ten distinct addresses through a four-entry queue.
      s_n = 10;
      for (int i = 0; i < 10; i++) begin
         s_addr[i] = 5'(i + 1);
         s_data[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      end
      run_stream();

      // Repeated addresses and a register-0 request mixed in.
      s_n = 7;
      s_addr[0] = 5'd7; s_data[0] = 32'h70;
      s_addr[1] = 5'd7; s_data[1] = 32'h71;
      s_addr[2] = 5'd0; s_data[2] = 32'hFFFF_FFFF;
      s_addr[3] = 5'd7; s_data[3] = 32'h72;
      s_addr[4] = 5'd3; s_data[4] = 32'h30;
      s_addr[5] = 5'd7; s_data[5] = 32'h73;
      s_addr[6] = 5'd3; s_data[6] = 32'h31;
      run_stream();

      // Reset during a strobe with three entries pending.
      in_valid = 1'b1; in_addr = 5'd10; in_data = 32'hA0;
      @(posedge clk); #1;
      in_addr = 5'd11; in_data = 32'hB0;
      @(posedge clk); #1;
      in_addr = 5'd12; in_data = 32'hC0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_addr = '0; in_data = '0;
      n_vec++;
      chk("midrst_pre_regwrite", 32'(regwrite), 32'd1);
      chk("midrst_pre_count", 32'(count), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      n_vec++;
      chk("midrst_regwrite", 32'(regwrite), 32'd0);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_writer", 32'(writer), 32'd0);
      chk("midrst_writedata", writedata, 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_vec++;
         chk("postrst_regwrite", 32'(regwrite), 32'd0);
         chk("postrst_count", 32'(count), 32'd0);
      end
      pend.delete();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
